// File: rtl/turf_event_frag_sched.sv
// Splits one event descriptor at a time into UDP fragments, issuing a UDP header
// and an event-buffer read command per fragment, with a programmable idle gap.
module turf_event_frag_sched #(
    parameter int LEN_BITS       = 20,
    parameter int ADDR_BITS      = 12,
    parameter int FRAG_HDR_BYTES = 8,
    parameter     DEBUG          = "FALSE"
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        event_open_i,
    input  logic [31:0] event_ip_i,
    input  logic [15:0] event_port_i,
    input  logic [9:0]  nfragment_count_i,
    input  logic [31:0] fragment_holdoff_i,
    input  logic [63:0] s_evhdr_tdata,
    input  logic        s_evhdr_tvalid,
    output logic        s_evhdr_tready,
    output logic [63:0] m_udphdr_tdata,
    output logic        m_udphdr_tvalid,
    input  logic        m_udphdr_tready,
    output logic [63:0] m_fragcmd_tdata,
    output logic        m_fragcmd_tvalid,
    input  logic        m_fragcmd_tready,
    output logic        m_fragcmd_tlast,
    output logic        busy_o,
    output logic        ev_drop_o,
    output logic [31:0] event_count_o
);

    // One extra bit: a maximum-length event rounds up to exactly 2^LEN_BITS bytes.
    localparam int REM_BITS = LEN_BITS + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_EMIT, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic [LEN_BITS-1:0]   len_q, len_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [31:0]           ip_q, ip_d;
    logic [15:0]           port_q, port_d;
    logic [15:0]           frag_sz_q, frag_sz_d;
    logic [31:0]           holdoff_q, holdoff_d;
    logic [REM_BITS-1:0]   rem_q, rem_d;
    logic [LEN_BITS-1:0]   off_q, off_d;
    logic [15:0]           idx_q, idx_d;
    logic                  hdr_done_q, hdr_done_d;
    logic                  cmd_done_q, cmd_done_d;
    logic [31:0]           hold_cnt_q, hold_cnt_d;
    logic [31:0]           ev_cnt_q, ev_cnt_d;

    logic [15:0]           frag_bytes;
    logic                  last_frag;
    logic                  hdr_fire;
    logic                  cmd_fire;
    logic                  frag_done;
    logic [REM_BITS-1:0]   len_rounded;
    logic                  unused_tdata;

    assign unused_tdata = ^{s_evhdr_tdata[31:LEN_BITS], s_evhdr_tdata[63:32+ADDR_BITS]};

    always_comb begin
        last_frag        = (rem_q <= REM_BITS'(frag_sz_q));
        frag_bytes       = last_frag ? rem_q[15:0] : frag_sz_q;
        len_rounded      = ({1'b0, len_q} + REM_BITS'(7)) & ~REM_BITS'(7);
        s_evhdr_tready   = (state_q == S_IDLE) && event_open_i && !areset;
        m_udphdr_tvalid  = (state_q == S_EMIT) && !hdr_done_q;
        m_fragcmd_tvalid = (state_q == S_EMIT) && !cmd_done_q;
        hdr_fire         = m_udphdr_tvalid && m_udphdr_tready;
        cmd_fire         = m_fragcmd_tvalid && m_fragcmd_tready;
        frag_done        = (hdr_done_q || hdr_fire) && (cmd_done_q || cmd_fire);
        m_udphdr_tdata   = {ip_q, port_q, frag_bytes + 16'(FRAG_HDR_BYTES)};
        m_fragcmd_tdata  = {idx_q, addr_q, frag_bytes, off_q};
        m_fragcmd_tlast  = last_frag;
        busy_o           = (state_q != S_IDLE);
        ev_drop_o        = (state_q == S_CALC) && (len_q == '0);
        event_count_o    = ev_cnt_q;
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        ip_d       = ip_q;
        port_d     = port_q;
        frag_sz_d  = frag_sz_q;
        holdoff_d  = holdoff_q;
        rem_d      = rem_q;
        off_d      = off_q;
        idx_d      = idx_q;
        hdr_done_d = hdr_done_q;
        cmd_done_d = cmd_done_q;
        hold_cnt_d = hold_cnt_q;
        ev_cnt_d   = ev_cnt_q;
        case (state_q)
            S_IDLE: begin
                // All configuration is frozen here for the lifetime of the event.
                if (s_evhdr_tvalid && s_evhdr_tready) begin
                    len_d     = s_evhdr_tdata[LEN_BITS-1:0];
                    addr_d    = s_evhdr_tdata[32 +: ADDR_BITS];
                    ip_d      = event_ip_i;
                    port_d    = event_port_i;
                    frag_sz_d = {2'b00, ({1'b0, nfragment_count_i} + 11'd1), 3'b000};
                    holdoff_d = fragment_holdoff_i;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                rem_d      = len_rounded;
                off_d      = '0;
                idx_d      = '0;
                hdr_done_d = 1'b0;
                cmd_done_d = 1'b0;
                state_d    = (len_q == '0) ? S_IDLE : S_EMIT;
            end
            S_EMIT: begin
                hdr_done_d = hdr_done_q || hdr_fire;
                cmd_done_d = cmd_done_q || cmd_fire;
                if (frag_done) begin
                    rem_d      = rem_q - REM_BITS'(frag_bytes);
                    off_d      = off_q + LEN_BITS'(frag_bytes);
                    idx_d      = idx_q + 16'd1;
                    hdr_done_d = 1'b0;
                    cmd_done_d = 1'b0;
                    // A zero holdoff skips HOLD entirely so fragments can go back to back.
                    if (holdoff_q != 32'd0) begin
                        hold_cnt_d = holdoff_q - 32'd1;
                        state_d    = S_HOLD;
                    end else if (last_frag) begin
                        ev_cnt_d = ev_cnt_q + 32'd1;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == 32'd0) begin
                    if (rem_q == '0) begin
                        ev_cnt_d = ev_cnt_q + 32'd1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_EMIT;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            hdr_done_q <= 1'b0;
            cmd_done_q <= 1'b0;
            hold_cnt_q <= 32'd0;
            ev_cnt_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            hdr_done_q <= hdr_done_d;
            cmd_done_q <= cmd_done_d;
            hold_cnt_q <= hold_cnt_d;
            ev_cnt_q   <= ev_cnt_d;
        end
        len_q     <= len_d;
        addr_q    <= addr_d;
        ip_q      <= ip_d;
        port_q    <= port_d;
        frag_sz_q <= frag_sz_d;
        holdoff_q <= holdoff_d;
        rem_q     <= rem_d;
        off_q     <= off_d;
        idx_q     <= idx_d;
    end

    generate
        if (DEBUG == "TRUE") begin : g_dbg
            logic [5:0] dbg_probe_q, dbg_probe_d;
            assign dbg_probe_d = {state_q, hdr_fire, cmd_fire, s_evhdr_tvalid && s_evhdr_tready, ev_drop_o};
            always_ff @(posedge aclk) begin
                dbg_probe_q <= dbg_probe_d;
            end
        end
    endgenerate

endmodule

// File: tb/tb_turf_event_frag_sched.sv
// Randomized and directed bench for turf_event_frag_sched against a fragment-list model.
module tb_turf_event_frag_sched;

    logic        clk = 1'b0;
    logic        areset;
    logic        event_open_i;
    logic [31:0] event_ip_i;
    logic [15:0] event_port_i;
    logic [9:0]  nfragment_count_i;
    logic [31:0] fragment_holdoff_i;
    logic [63:0] s_evhdr_tdata;
    logic        s_evhdr_tvalid;
    logic        s_evhdr_tready;
    logic [63:0] m_udphdr_tdata;
    logic        m_udphdr_tvalid;
    logic        m_udphdr_tready;
    logic [63:0] m_fragcmd_tdata;
    logic        m_fragcmd_tvalid;
    logic        m_fragcmd_tready;
    logic        m_fragcmd_tlast;
    logic        busy_o;
    logic        ev_drop_o;
    logic [31:0] event_count_o;

    always #5 clk = ~clk;

    turf_event_frag_sched dut (
        .aclk              (clk),
        .areset            (areset),
        .event_open_i      (event_open_i),
        .event_ip_i        (event_ip_i),
        .event_port_i      (event_port_i),
        .nfragment_count_i (nfragment_count_i),
        .fragment_holdoff_i(fragment_holdoff_i),
        .s_evhdr_tdata     (s_evhdr_tdata),
        .s_evhdr_tvalid    (s_evhdr_tvalid),
        .s_evhdr_tready    (s_evhdr_tready),
        .m_udphdr_tdata    (m_udphdr_tdata),
        .m_udphdr_tvalid   (m_udphdr_tvalid),
        .m_udphdr_tready   (m_udphdr_tready),
        .m_fragcmd_tdata   (m_fragcmd_tdata),
        .m_fragcmd_tvalid  (m_fragcmd_tvalid),
        .m_fragcmd_tready  (m_fragcmd_tready),
        .m_fragcmd_tlast   (m_fragcmd_tlast),
        .busy_o            (busy_o),
        .ev_drop_o         (ev_drop_o),
        .event_count_o     (event_count_o)
    );

    typedef struct {
        logic [63:0] hdr;
        logic [63:0] cmd;
        logic        last;
    } frag_t;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    frag_t       exp_q[$];
    logic [63:0] hdr_log[$];
    logic [64:0] cmd_log[$];
    int          drop_cnt = 0;

    bit          rand_rdy = 1'b0;
    logic        hdr_rdy_set = 1'b1;
    logic        cmd_rdy_set = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected fragment list of one event, straight from the fragmenting rules.
    function automatic void build(input longint len, input logic [11:0] addr, input logic [31:0] ip,
                                  input logic [15:0] port, input logic [9:0] n);
        longint total = ((len + 7) / 8) * 8;
        longint fsz   = (longint'(n) + 1) * 8;
        longint rem   = total;
        longint off   = 0;
        longint idx   = 0;
        longint b;
        frag_t  f;
        while (rem > 0) begin
            b      = (rem < fsz) ? rem : fsz;
            f.hdr  = {ip, port, 16'(b + 8)};
            f.cmd  = {16'(idx), addr, 16'(b), 20'(off)};
            f.last = (rem <= fsz);
            exp_q.push_back(f);
            rem -= b;
            off += b;
            idx++;
        end
    endfunction

    // Cycle-level model: which outputs must be up in each cycle, and with what content.
    longint      cyc = 0;
    bit          m_active = 1'b0;
    longint      m_next_emit = 0;
    longint      m_end = 0;
    bit          m_end_set = 1'b0;
    bit          m_count = 1'b0;
    bit          m_hdr_taken = 1'b0;
    bit          m_cmd_taken = 1'b0;
    longint      m_drop_cyc = -1;
    int unsigned m_evcnt = 0;
    longint      m_hold = 0;

    initial begin
        bit in_frag, e_hv, e_cv, e_tr;
        forever begin
            @(negedge clk);
            cyc++;
            if (areset) begin
                chk("tready_in_reset", 64'(s_evhdr_tready), 64'd0);
                exp_q.delete();
                m_active    = 1'b0;
                m_end_set   = 1'b0;
                m_hdr_taken = 1'b0;
                m_cmd_taken = 1'b0;
                m_drop_cyc  = -1;
                m_evcnt     = 0;
            end else begin
                if (m_active && m_end_set && cyc == m_end) begin
                    m_active  = 1'b0;
                    m_end_set = 1'b0;
                    if (m_count) m_evcnt++;
                end
                in_frag = m_active && (exp_q.size() > 0) && (cyc >= m_next_emit);
                e_hv    = in_frag && !m_hdr_taken;
                e_cv    = in_frag && !m_cmd_taken;
                e_tr    = !m_active && event_open_i;
                chk("busy", 64'(busy_o), 64'(m_active));
                chk("ev_drop", 64'(ev_drop_o), 64'(cyc == m_drop_cyc));
                chk("udphdr_tvalid", 64'(m_udphdr_tvalid), 64'(e_hv));
                chk("fragcmd_tvalid", 64'(m_fragcmd_tvalid), 64'(e_cv));
                chk("evhdr_tready", 64'(s_evhdr_tready), 64'(e_tr));
                chk("event_count", 64'(event_count_o), 64'(m_evcnt));
                if (e_hv && m_udphdr_tvalid)
                    chk("udphdr_tdata", m_udphdr_tdata, exp_q[0].hdr);
                if (e_cv && m_fragcmd_tvalid) begin
                    chk("fragcmd_tdata", m_fragcmd_tdata, exp_q[0].cmd);
                    chk("fragcmd_tlast", 64'(m_fragcmd_tlast), 64'(exp_q[0].last));
                end
                if (m_udphdr_tvalid && m_udphdr_tready) hdr_log.push_back(m_udphdr_tdata);
                if (m_fragcmd_tvalid && m_fragcmd_tready) cmd_log.push_back({m_fragcmd_tlast, m_fragcmd_tdata});
                if (ev_drop_o) drop_cnt++;
                if (in_frag) begin
                    if (e_hv && m_udphdr_tready) m_hdr_taken = 1'b1;
                    if (e_cv && m_fragcmd_tready) m_cmd_taken = 1'b1;
                    if (m_hdr_taken && m_cmd_taken) begin
                        void'(exp_q.pop_front());
                        m_hdr_taken = 1'b0;
                        m_cmd_taken = 1'b0;
                        if (exp_q.size() == 0) begin
                            m_end     = cyc + 1 + m_hold;
                            m_end_set = 1'b1;
                            m_count   = 1'b1;
                        end else begin
                            m_next_emit = cyc + 1 + m_hold;
                        end
                    end
                end
                if (e_tr && s_evhdr_tvalid) begin
                    m_active = 1'b1;
                    m_hold   = longint'(fragment_holdoff_i);
                    if (s_evhdr_tdata[19:0] == 20'd0) begin
                        m_drop_cyc = cyc + 1;
                        m_end      = cyc + 2;
                        m_end_set  = 1'b1;
                        m_count    = 1'b0;
                    end else begin
                        build(longint'(s_evhdr_tdata[19:0]), s_evhdr_tdata[43:32], event_ip_i,
                              event_port_i, nfragment_count_i);
                        m_next_emit = cyc + 2;
                        m_end_set   = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        m_udphdr_tready  = 1'b1;
        m_fragcmd_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) begin
                m_udphdr_tready  = ($urandom_range(0, 9) < 7);
                m_fragcmd_tready = ($urandom_range(0, 9) < 6);
            end else begin
                m_udphdr_tready  = hdr_rdy_set;
                m_fragcmd_tready = cmd_rdy_set;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_event(input logic [19:0] len, input logic [11:0] addr);
        bit got = 1'b0;
        s_evhdr_tdata  = {20'($urandom), addr, 12'($urandom), len};
        s_evhdr_tvalid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (s_evhdr_tready) begin
                got = 1'b1;
                break;
            end
        end
        chk("send_timeout", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        s_evhdr_tvalid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        bit ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        hdr_log.delete();
        cmd_log.delete();
    endtask

    task automatic set_cfg(input logic [9:0] n, input logic [31:0] h);
        nfragment_count_i  = n;
        fragment_holdoff_i = h;
    endtask

    initial begin
        int d0;
        areset             = 1'b1;
        event_open_i       = 1'b0;
        event_ip_i         = 32'hC0A8_0101;
        event_port_i       = 16'd5000;
        nfragment_count_i  = 10'd127;
        fragment_holdoff_i = 32'd0;
        s_evhdr_tdata      = 64'd0;
        s_evhdr_tvalid     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_evcnt", 64'(event_count_o), 64'd0);
        chk("reset_hdr_vld", 64'(m_udphdr_tvalid), 64'd0);
        @(posedge clk);
        #1;

        // 3000 bytes in 1 KiB fragments
        event_open_i = 1'b1;
        set_cfg(10'd127, 32'd0);
        clear_logs();
        send_event(20'd3000, 12'h123);
        wait_idle(200);
        chk("f3_count", 64'(cmd_log.size()), 64'd3);
        if (cmd_log.size() == 3 && hdr_log.size() == 3) begin
            chk("f3_bytes0", 64'(cmd_log[0][35:20]), 64'd1024);
            chk("f3_bytes2", 64'(cmd_log[2][35:20]), 64'd952);
            chk("f3_off1", 64'(cmd_log[1][19:0]), 64'd1024);
            chk("f3_off2", 64'(cmd_log[2][19:0]), 64'd2048);
            chk("f3_udp0", 64'(hdr_log[0][15:0]), 64'd1032);
            chk("f3_udp2", 64'(hdr_log[2][15:0]), 64'd960);
            chk("f3_tlast1", 64'(cmd_log[1][64]), 64'd0);
            chk("f3_tlast2", 64'(cmd_log[2][64]), 64'd1);
            chk("f3_idx2", 64'(cmd_log[2][63:48]), 64'd2);
            chk("f3_addr", 64'(cmd_log[0][47:36]), 64'h123);
        end
        chk("f3_evcnt", 64'(event_count_o), 64'd1);

        clear_logs();
        send_event(20'd1000, 12'h001);
        wait_idle(200);
        chk("f1000_count", 64'(cmd_log.size()), 64'd1);
        if (cmd_log.size() == 1) begin
            chk("f1000_bytes", 64'(cmd_log[0][35:20]), 64'd1000);
            chk("f1000_tlast", 64'(cmd_log[0][64]), 64'd1);
        end

        clear_logs();
        send_event(20'd13, 12'h002);
        wait_idle(200);
        chk("f13_count", 64'(hdr_log.size()), 64'd1);
        if (cmd_log.size() == 1 && hdr_log.size() == 1) begin
            chk("f13_bytes", 64'(cmd_log[0][35:20]), 64'd16);
            chk("f13_udp", 64'(hdr_log[0][15:0]), 64'd24);
        end

        // holdoff of 5 between and after fragments
        set_cfg(10'd127, 32'd5);
        clear_logs();
        send_event(20'd2048, 12'h003);
        wait_idle(200);
        chk("hold_count", 64'(cmd_log.size()), 64'd2);

        // command channel stalled while the header is taken
        set_cfg(10'd127, 32'd0);
        clear_logs();
        cmd_rdy_set = 1'b0;
        send_event(20'd2048, 12'h004);
        repeat (12) @(posedge clk);
        #1;
        chk("stall_hdr_once", 64'(hdr_log.size()), 64'd1);
        chk("stall_no_cmd", 64'(cmd_log.size()), 64'd0);
        cmd_rdy_set = 1'b1;
        wait_idle(200);
        chk("stall_cmd_done", 64'(cmd_log.size()), 64'd2);
        chk("stall_hdr_done", 64'(hdr_log.size()), 64'd2);

        // channel closed: descriptor must not be taken
        event_open_i   = 1'b0;
        s_evhdr_tdata  = 64'd100;
        s_evhdr_tvalid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("closed_busy", 64'(busy_o), 64'd0);
        s_evhdr_tvalid = 1'b0;

        // channel closed mid-event: event finishes with latched destination
        event_open_i = 1'b1;
        clear_logs();
        send_event(20'd3000, 12'h005);
        event_open_i = 1'b0;
        event_ip_i   = 32'h0A00_0009;
        event_port_i = 16'd77;
        wait_idle(200);
        chk("close_mid_count", 64'(hdr_log.size()), 64'd3);
        if (hdr_log.size() == 3) chk("close_mid_ip", 64'(hdr_log[2][63:32]), 64'hC0A8_0101);
        event_open_i = 1'b1;

        // zero-length event
        clear_logs();
        d0 = drop_cnt;
        send_event(20'd0, 12'h006);
        wait_idle(50);
        chk("drop_pulses", 64'(drop_cnt - d0), 64'd1);
        chk("drop_no_cmd", 64'(cmd_log.size()), 64'd0);

        // reset while fragments are pending
        hdr_rdy_set = 1'b0;
        cmd_rdy_set = 1'b0;
        send_event(20'd3000, 12'h007);
        repeat (4) @(posedge clk);
        #1;
        areset = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy_o), 64'd0);
        chk("rst_mid_vld", 64'({m_udphdr_tvalid, m_fragcmd_tvalid}), 64'd0);
        chk("rst_mid_evcnt", 64'(event_count_o), 64'd0);
        @(posedge clk);
        #1;
        hdr_rdy_set = 1'b1;
        cmd_rdy_set = 1'b1;

        // randomized traffic
        rand_rdy = 1'b1;
        for (int e = 0; e < 40; e++) begin
            logic [19:0] len;
            event_ip_i   = $urandom;
            event_port_i = 16'($urandom);
            set_cfg(10'($urandom_range(31, 200)), 32'($urandom_range(0, 3)));
            len = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(0, 1)) * 20'($urandom_range(1, 7))
                                              : 20'($urandom_range(1, 6000));
            event_open_i = 1'b1;
            send_event(len, 12'($urandom));
            event_ip_i   = $urandom;
            event_port_i = 16'($urandom);
            set_cfg(10'($urandom_range(0, 1023)), 32'($urandom_range(0, 9)));
            event_open_i = ($urandom_range(0, 1) == 1);
            wait_idle(5000);
        end
        rand_rdy     = 1'b0;
        event_open_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
